// File: rtl/lcd_instr_engine.sv
// lcd_instr_engine: 4-bit character-LCD instruction transmitter.
// One command per valid/ready handshake, internally timed nibble strobes.
module lcd_instr_engine #(
  parameter int SETUP_CYC      = 2,
  parameter int PULSE_CYC      = 12,
  parameter int HOLD_CYC       = 1,
  parameter int GAP_CYC        = 50,
  parameter int WAIT_SHORT_CYC = 2000,
  parameter int WAIT_LONG_CYC  = 82000,
  parameter int CNT_W          = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       instr_rs,
  input  logic       instr_rw,
  input  logic [7:0] instr_data,
  input  logic       instr_long,
  input  logic       instr_nibble_only,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [3:0] SF_D,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE,
    SETUP_H,
    PULSE_H,
    HOLD_H,
    GAP,
    SETUP_L,
    PULSE_L,
    HOLD_L,
    WAIT
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LAST =
    CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST =
    CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] WS_LAST =
    CNT_W'(WAIT_SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] WL_LAST =
    CNT_W'(WAIT_LONG_CYC - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wait_last;

  logic       rs_q;
  logic       rw_q;
  logic [7:0] data_q;
  logic       long_q;
  logic       nib_q;

  logic       accept;
  logic       rs_d;
  logic       rw_d;
  logic [7:0] data_d;
  logic       nib_d;

  logic       is_hi;
  logic       is_lo;
  logic       rs_n;
  logic       rw_n;
  logic       e_n;
  logic [3:0] sf_n;

  assign accept = instr_valid && instr_ready;

  // Command fields as they will be after this edge, so the
  // registered outputs see a new command on its acceptance edge.
  assign rs_d   = accept ? instr_rs          : rs_q;
  assign rw_d   = accept ? instr_rw          : rw_q;
  assign data_d = accept ? instr_data        : data_q;
  assign nib_d  = accept ? instr_nibble_only : nib_q;

  assign wait_last = long_q ? WL_LAST : WS_LAST;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; each timed state ends at cnt == N-1.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) state_n = SETUP_H;
      end
      SETUP_H: begin
        if (cnt == SETUP_LAST) state_n = PULSE_H;
      end
      PULSE_H: begin
        if (cnt == PULSE_LAST) state_n = HOLD_H;
      end
      HOLD_H: begin
        if (cnt == HOLD_LAST) begin
          state_n = nib_q ? WAIT : GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) state_n = SETUP_L;
      end
      SETUP_L: begin
        if (cnt == SETUP_LAST) state_n = PULSE_L;
      end
      PULSE_L: begin
        if (cnt == PULSE_LAST) state_n = HOLD_L;
      end
      HOLD_L: begin
        if (cnt == HOLD_LAST) state_n = WAIT;
      end
      WAIT: begin
        if (cnt == wait_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Phase counter, cleared on every state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_n != state) begin
      cnt <= '0;
    end else if (state != IDLE) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Command latch, loaded only on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_q   <= 1'b0;
      rw_q   <= 1'b0;
      data_q <= 8'h00;
      long_q <= 1'b0;
      nib_q  <= 1'b0;
    end else if (accept) begin
      rs_q   <= instr_rs;
      rw_q   <= instr_rw;
      data_q <= instr_data;
      long_q <= instr_long;
      nib_q  <= instr_nibble_only;
    end
  end

  // Pin values decoded from the state being entered.
  always_comb begin
    is_hi = (state_n == SETUP_H) ||
            (state_n == PULSE_H) ||
            (state_n == HOLD_H);
    is_lo = (state_n == SETUP_L) ||
            (state_n == PULSE_L) ||
            (state_n == HOLD_L);
    e_n   = (state_n == PULSE_H) ||
            (state_n == PULSE_L);
    rs_n  = 1'b0;
    rw_n  = 1'b0;
    sf_n  = 4'h0;
    unique case (1'b1)
      is_hi: begin
        rs_n = rs_d;
        rw_n = rw_d;
        sf_n = data_d[7:4];
      end
      is_lo: begin
        rs_n = rs_d;
        rw_n = rw_d;
        sf_n = data_d[3:0];
      end
      (state_n == GAP): begin
        sf_n = data_d[7:4];
      end
      (state_n == WAIT): begin
        sf_n = nib_d ? data_d[7:4] : data_d[3:0];
      end
      default: ;
    endcase
  end

  // Registered pins, handshake and completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LCD_RS      <= 1'b0;
      LCD_RW      <= 1'b0;
      LCD_E       <= 1'b0;
      SF_D        <= 4'h0;
      instr_ready <= 1'b0;
      done        <= 1'b0;
    end else begin
      LCD_RS      <= rs_n;
      LCD_RW      <= rw_n;
      LCD_E       <= e_n;
      SF_D        <= sf_n;
      instr_ready <= (state_n == IDLE);
      done        <= (state == WAIT) &&
                     (state_n == IDLE);
    end
  end

endmodule

// File: tb/tb_lcd_instr_engine.sv
// tb_lcd_instr_engine: timeline model check of lcd_instr_engine.
// Directed commands plus literal latency and strobe-count checks.
module tb_lcd_instr_engine;

  localparam int S  = 2;
  localparam int P  = 12;
  localparam int H  = 1;
  localparam int G  = 50;
  localparam int WS = 2000;
  localparam int WL = 82000;
  localparam int N1 = S + P + H;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic       instr_rs = 1'b0;
  logic       instr_rw = 1'b0;
  logic [7:0] instr_data = 8'h00;
  logic       instr_long = 1'b0;
  logic       instr_nibble_only = 1'b0;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_E;
  logic [3:0] SF_D;
  logic       done;

  lcd_instr_engine dut (
    .clk              (clk),
    .reset            (reset),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_rs         (instr_rs),
    .instr_rw         (instr_rw),
    .instr_data       (instr_data),
    .instr_long       (instr_long),
    .instr_nibble_only(instr_nibble_only),
    .LCD_RS           (LCD_RS),
    .LCD_RW           (LCD_RW),
    .LCD_E            (LCD_E),
    .SF_D             (SF_D),
    .done             (done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;

  // model state: p = cycle number within the command (1 = after
  // the acceptance edge), per the command timeline
  bit       m_busy = 0;
  bit       m_ready = 0;
  bit       m_done = 0;
  int       m_p = 0;
  int       m_total = 0;
  bit       m_rs = 0;
  bit       m_rw = 0;
  bit       m_nib = 0;
  bit [7:0] m_data = 0;
  int       cyc = 0;
  int       acc_cnt = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy  = 0;
      m_ready = 0;
      m_done  = 0;
      m_p     = 0;
    end else begin
      cyc++;
      if (m_busy) begin
        m_p++;
        if (m_p == m_total) begin
          m_busy  = 0;
          m_done  = 1;
          m_ready = 1;
        end
      end else begin
        m_done = 0;
        if (m_ready && instr_valid) begin
          m_rs    = instr_rs;
          m_rw    = instr_rw;
          m_nib   = instr_nibble_only;
          m_data  = instr_data;
          m_total = 1 + N1 + (instr_long ? WL : WS);
          if (!instr_nibble_only) m_total += N1 + G;
          m_busy  = 1;
          m_p     = 1;
          m_ready = 0;
          acc_cnt++;
        end else begin
          m_ready = 1;
        end
      end
    end
  end

  // {RS, RW, E, D[3:0], ready, done}
  function automatic logic [8:0] expect_out();
    logic [3:0] hi;
    logic [3:0] lo;
    int q;
    hi = m_data[7:4];
    lo = m_data[3:0];
    if (!m_busy) return {3'b000, 4'h0, m_ready, m_done};
    if (m_p <= N1) begin
      q = m_p;
      return {m_rs, m_rw, (q > S && q <= S + P), hi, 2'b00};
    end
    if (!m_nib && m_p <= N1 + G)
      return {3'b000, hi, 2'b00};
    if (!m_nib && m_p <= 2 * N1 + G) begin
      q = m_p - N1 - G;
      return {m_rs, m_rw, (q > S && q <= S + P), lo, 2'b00};
    end
    return {3'b000, (m_nib ? hi : lo), 2'b00};
  endfunction

  int acc_edge = 0;
  int e_cnt = 0;
  int rs_cnt = 0;
  int done_cnt = 0;
  int last_lat = 0;
  int last_e = 0;
  int last_rs = 0;

  // Per-cycle compare against the model, plus DUT-side meters.
  always @(negedge clk) begin
    logic [8:0] act;
    logic [8:0] exp_v;
    act   = {LCD_RS, LCD_RW, LCD_E, SF_D, instr_ready, done};
    exp_v = expect_out();
    n_assert++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL pins cyc=%0d p=%0d got=%b want=%b",
               cyc, m_p, act, exp_v);
    end
    if (LCD_E === 1'b1) e_cnt++;
    if (LCD_RS === 1'b1) rs_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      last_lat = cyc - acc_edge + 1;
      last_e   = e_cnt;
      last_rs  = rs_cnt;
    end
    if (instr_valid && instr_ready === 1'b1 && !reset) begin
      acc_edge = cyc + 1;
      e_cnt    = 0;
      rs_cnt   = 0;
    end
  end

  task automatic check(input string name, input int act,
                       input int req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end
  endtask

  task automatic wait_acc(input int bound);
    int s;
    s = acc_cnt;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != s) return;
    end
    check("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int bound);
    int s;
    s = done_cnt;
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != s) return;
    end
    check("done_timeout", 0, 1);
  endtask

  int dc;

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", instr_ready, 0);
    check("rst_e", LCD_E, 0);
    check("rst_pins", {LCD_RS, LCD_RW, SF_D, done}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rel", instr_ready, 1);

    // 0x28 short, valid held; data changes before next accept
    instr_valid = 1'b1;
    instr_data  = 8'h28;
    wait_acc(5);
    instr_data  = 8'h41;
    instr_rs    = 1'b1;
    instr_long  = 1'b1;
    wait_done(3000);
    check("lat_28", last_lat, 2081);
    check("e_28", last_e, 24);
    check("rs_28", last_rs, 0);
    check("b2b_accept", acc_cnt, 2);

    // 0x41 long, accepted on the done cycle
    instr_valid = 1'b0;
    instr_data  = 8'hFF;
    instr_rs    = 1'b0;
    instr_long  = 1'b0;
    wait_done(90000);
    check("lat_41", last_lat, 82081);
    check("e_41", last_e, 24);
    check("rs_41", last_rs, 30);

    // nibble-only 0x30
    instr_valid       = 1'b1;
    instr_data        = 8'h30;
    instr_nibble_only = 1'b1;
    wait_acc(5);
    instr_valid       = 1'b0;
    instr_nibble_only = 1'b0;
    instr_data        = 8'h00;
    wait_done(3000);
    check("lat_30", last_lat, 2016);
    check("e_30", last_e, 12);

    // reset in cycle 40 of a command
    instr_valid = 1'b1;
    instr_data  = 8'h28;
    wait_acc(5);
    instr_valid = 1'b0;
    repeat (39) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_pins",
          {LCD_RS, LCD_RW, LCD_E, SF_D, instr_ready, done}, 0);
    dc = done_cnt;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    instr_valid       = 1'b1;
    instr_data        = 8'h30;
    instr_nibble_only = 1'b1;
    wait_acc(5);
    instr_valid       = 1'b0;
    instr_nibble_only = 1'b0;
    wait_done(3000);
    check("no_done_abort", done_cnt, dc + 1);
    check("lat_after_rst", last_lat, 2016);
    check("e_after_rst", last_e, 12);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
